lsu_arb: RTL and testbench



---
 rtl/lsu_arb_pkg.sv | 68 ++++++
 rtl/lsu_arb_starve_ctr.sv | 44 ++++
 rtl/lsu_arb.sv | 115 +++++++++++
 tb/tb_lsu_arb.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_arb_pkg.sv
// Shared types for the LSU arbiter: request payload, requester index and
// small one-hot helpers used by the selection logic.
package lsu_arb_pkg;

  localparam int NUM_REQ = 4;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
  localparam int LQ_W   = 8;
  localparam int SQ_W   = 8;

  typedef logic [ADDR_W-1:0] procyon_addr_t;
  typedef logic [DATA_W-1:0] procyon_data_t;
  typedef logic [TAG_W-1:0]  procyon_tag_t;
  typedef logic [LQ_W-1:0]   procyon_lq_select_t;
  typedef logic [SQ_W-1:0]   procyon_sq_select_t;

  typedef enum logic [3:0] {
    LSU_FUNC_LB  = 4'd0,
    LSU_FUNC_LH  = 4'd1,
    LSU_FUNC_LW  = 4'd2,
    LSU_FUNC_LBU = 4'd3,
    LSU_FUNC_LHU = 4'd4,
    LSU_FUNC_SB  = 4'd5,
    LSU_FUNC_SH  = 4'd6,
    LSU_FUNC_SW  = 4'd7,
    LSU_FUNC_FILL = 4'd8
  } procyon_lsu_func_t;

  typedef struct packed {
    procyon_lsu_func_t  lsu_func;
    procyon_addr_t      addr;
    procyon_data_t      data;
    procyon_tag_t       tag;
    procyon_lq_select_t lq_select;
    procyon_sq_select_t sq_select;
  } procyon_lsu_req_t;

  // Requester index; the numeric value doubles as the request-vector bit.
  typedef enum logic [1:0] {
    LSU_SRC_FILL = 2'd0,
    LSU_SRC_SQ   = 2'd1,
    LSU_SRC_LQ   = 2'd2,
    LSU_SRC_RS   = 2'd3
  } procyon_lsu_src_t;

  // Isolate the lowest set bit; zero in gives zero out.
  function automatic logic [NUM_REQ-1:0] lowest_onehot(input logic [NUM_REQ-1:0] v);
    return v & (~v + {{(NUM_REQ-1){1'b0}}, 1'b1});
  endfunction

  // Encode a one-hot grant into a requester index (FILL when empty).
  function automatic procyon_lsu_src_t onehot_to_src(input logic [NUM_REQ-1:0] g);
    procyon_lsu_src_t src;
    src = LSU_SRC_FILL;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g[i]) src = procyon_lsu_src_t'(2'(i));
    end
    return src;
  endfunction

  // Requests that a pipeline flush kills: LQ replays and new RS ops.
  function automatic logic is_flushable(input procyon_lsu_src_t src);
    return (src == LSU_SRC_LQ) || (src == LSU_SRC_RS);
  endfunction

endpackage

// File: rtl/lsu_arb_starve_ctr.sv
// Per-requester starvation counter: counts consecutive cycles a request is
// valid but not acknowledged, saturating at STARVE_LIMIT, and flags the
// requester as urgent once the limit is reached.
module lsu_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic i_ack,
  input  logic i_clear,
  output logic o_urgent
);

  localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: any break in waiting restarts it, otherwise saturate upward.
  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d -- no latch.
    cnt_d = cnt_q;
    if (!i_valid || i_ack || i_clear) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter state with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for all flop state so every flop samples pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_urgent = (cnt_q == LIMIT);

endmodule

// File: rtl/lsu_arb.sv
// Four-way arbiter feeding the LSU execute pipeline. Picks one requester per
// cycle (fill > SQ retire > LQ replay > RS op) with starvation promotion for
// requesters 1..3, and registers the winner into a one-entry output stage
// that honours downstream stall and drops flushed LQ/RS work.
module lsu_arb
  import lsu_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_flush,
  input  logic                              i_stall,
  input  logic             [NUM_REQ-1:0]    i_req_valid,
  input  procyon_lsu_req_t [NUM_REQ-1:0]    i_req,
  output logic             [NUM_REQ-1:0]    o_req_ack,
  output logic                              o_valid,
  output procyon_lsu_req_t                  o_req,
  output procyon_lsu_src_t                  o_src,
  output logic                              o_retire
);

  // Output stage state.
  logic             valid_q,  valid_d;
  procyon_lsu_req_t req_q,    req_d;
  procyon_lsu_src_t src_q,    src_d;
  logic             retire_q, retire_d;

  // Selection signals.
  logic                 accept;
  logic [NUM_REQ-1:0]   masked_valid;
  logic [NUM_REQ-1:0]   urgent;
  logic [NUM_REQ-1:0]   urgent_valid;
  logic [NUM_REQ-1:0]   grant;
  procyon_lsu_src_t     win_src;

  // Fill requests are never promoted: they already have top priority.
  assign urgent[LSU_SRC_FILL] = 1'b0;

  for (genvar i = 1; i < NUM_REQ; i++) begin : g_starve
    lsu_arb_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
    ) u_ctr (
      .clk      (clk),
      .rst      (rst),
      .i_valid  (i_req_valid[i]),
      .i_ack    (o_req_ack[i]),
      .i_clear  ((i >= 2) ? i_flush : 1'b0),
      .o_urgent (urgent[i])
    );
  end

  // Winner selection: urgent requesters first, then plain fixed priority.
  always_comb begin
    accept       = ~valid_q | ~i_stall;
    masked_valid = i_req_valid;
    if (i_flush) begin
      masked_valid[LSU_SRC_LQ] = 1'b0;
      masked_valid[LSU_SRC_RS] = 1'b0;
    end
    urgent_valid = masked_valid & urgent;
    grant        = (|urgent_valid) ? lowest_onehot(urgent_valid)
                                   : lowest_onehot(masked_valid);
    win_src      = onehot_to_src(grant);
  end

  // Acknowledge only when the output stage can take the winner.
  always_comb begin
    o_req_ack = '0;
    if (!rst && accept) begin
      o_req_ack = grant;
    end
  end

  // Output stage next state: load on accept, else hold or drop flushed work.
  always_comb begin
    valid_d  = valid_q;
    req_d    = req_q;
    src_d    = src_q;
    retire_d = retire_q;
    if (accept) begin
      valid_d  = |masked_valid;
      req_d    = i_req[win_src];
      src_d    = win_src;
      retire_d = (win_src == LSU_SRC_SQ);
    end else if (i_flush && is_flushable(src_q)) begin
      valid_d  = 1'b0;
    end
  end

  // Control flops of the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      src_q    <= LSU_SRC_FILL;
      retire_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      src_q    <= src_d;
      retire_q <= retire_d;
    end
  end

  // Payload flops of the output stage.
  always_ff @(posedge clk) begin
    // NOTE: payload is qualified by o_valid, so it is left unreset.
    req_q <= req_d;
  end

  assign o_valid  = valid_q;
  assign o_req    = req_q;
  assign o_src    = src_q;
  assign o_retire = retire_q;

endmodule

// File: tb/tb_lsu_arb.sv
// Directed bench for lsu_arb: every accepted request is pushed to a
// scoreboard when its ack is seen and popped when it appears at the output.
module tb_lsu_arb;
  import lsu_arb_pkg::*;

  localparam int STARVE_LIMIT = 8;

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           i_flush;
  logic                           i_stall;
  logic             [NUM_REQ-1:0] i_req_valid;
  procyon_lsu_req_t [NUM_REQ-1:0] i_req;
  logic             [NUM_REQ-1:0] o_req_ack;
  logic                           o_valid;
  procyon_lsu_req_t               o_req;
  procyon_lsu_src_t               o_src;
  logic                           o_retire;

  lsu_arb #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (i_flush),
    .i_stall     (i_stall),
    .i_req_valid (i_req_valid),
    .i_req       (i_req),
    .o_req_ack   (o_req_ack),
    .o_valid     (o_valid),
    .o_req       (o_req),
    .o_src       (o_src),
    .o_retire    (o_retire)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    procyon_lsu_src_t src;
    procyon_lsu_req_t req;
  } exp_t;

  exp_t             sb[$];
  procyon_lsu_req_t held;
  int               tests  = 0;
  int               failed = 0;
  int               seq    = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic procyon_lsu_req_t make_req(input int idx, input int s);
    procyon_lsu_req_t r;
    r.lsu_func  = procyon_lsu_func_t'(4'(idx));
    r.addr      = procyon_addr_t'(32'h1000_0000 * (idx + 1) + s);
    r.data      = ~r.addr;
    r.tag       = procyon_tag_t'(s);
    r.lq_select = procyon_lq_select_t'(idx * 16 + s);
    r.sq_select = procyon_sq_select_t'(s * 3 + idx);
    return r;
  endfunction

  // One clock of stimulus, entered and left at the falling edge.
  task automatic cycle(input logic [3:0] valid, input logic stall, input logic flush,
                       input logic [3:0] exp_ack, input string tag);
    exp_t e;
    int   idx;
    logic pushed;
    seq++;
    i_req_valid = valid;
    i_stall     = stall;
    i_flush     = flush;
    for (int i = 0; i < NUM_REQ; i++) i_req[i] = make_req(i, seq);
    #1;
    check({tag, " ack"}, 128'(o_req_ack), 128'(exp_ack));
    pushed = 1'b0;
    if (exp_ack != 4'b0000) begin
      idx = 0;
      for (int i = 0; i < NUM_REQ; i++) if (exp_ack[i]) idx = i;
      e.src = procyon_lsu_src_t'(2'(idx));
      e.req = i_req[idx];
      sb.push_back(e);
      pushed = 1'b1;
    end
    @(posedge clk);
    #1;
    if (pushed) begin
      e = sb.pop_front();
      check({tag, " valid"},  128'(o_valid),  128'(1'b1));
      check({tag, " src"},    128'(o_src),    128'(e.src));
      check({tag, " req"},    128'(o_req),    128'(e.req));
      check({tag, " retire"}, 128'(o_retire), 128'(e.src == LSU_SRC_SQ));
      held = e.req;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    i_flush     = 1'b0;
    i_stall     = 1'b0;
    i_req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) i_req[i] = make_req(i, 0);
    @(negedge clk);

    // Reset: acks forced off even with every requester valid.
    cycle(4'b1111, 1'b0, 1'b0, 4'b0000, "reset");
    check("reset o_valid",  128'(o_valid),  128'(1'b0));
    check("reset o_retire", 128'(o_retire), 128'(1'b0));
    check("reset o_src",    128'(o_src),    128'(LSU_SRC_FILL));
    rst = 1'b0;

    // Fixed priority: fill wins while it keeps requesting.
    for (int k = 0; k < 3; k++) cycle(4'b1111, 1'b0, 1'b0, 4'b0001, "fill_prio");
    cycle(4'b0000, 1'b0, 1'b0, 4'b0000, "idle");
    check("idle o_valid", 128'(o_valid), 128'(1'b0));

    // Starvation: RS op promoted after exactly STARVE_LIMIT waiting cycles.
    for (int k = 0; k < STARVE_LIMIT; k++) cycle(4'b1001, 1'b0, 1'b0, 4'b0001, "starve_wait");
    cycle(4'b1001, 1'b0, 1'b0, 4'b1000, "starve_promote");
    cycle(4'b1001, 1'b0, 1'b0, 4'b0001, "starve_cleared");
    cycle(4'b0000, 1'b0, 1'b0, 4'b0000, "idle2");

    // Flush filter: SQ retire still acked during flush; LQ/RS masked.
    cycle(4'b1110, 1'b0, 1'b1, 4'b0010, "flush_sq_ack");
    cycle(4'b1100, 1'b0, 1'b1, 4'b0000, "flush_mask");
    check("flush_mask o_valid", 128'(o_valid), 128'(1'b0));

    // Held LQ entry is dropped by flush even while stalled.
    cycle(4'b0100, 1'b0, 1'b0, 4'b0100, "lq_load");
    cycle(4'b0100, 1'b1, 1'b0, 4'b0000, "lq_stall");
    check("lq_stall o_valid", 128'(o_valid), 128'(1'b1));
    check("lq_stall o_src",   128'(o_src),   128'(LSU_SRC_LQ));
    cycle(4'b1100, 1'b1, 1'b1, 4'b0000, "lq_flush");
    check("lq_flush o_valid", 128'(o_valid), 128'(1'b0));

    // Held SQ retire entry survives flush under stall.
    cycle(4'b0010, 1'b0, 1'b0, 4'b0010, "sq_load");
    cycle(4'b1110, 1'b1, 1'b1, 4'b0000, "sq_flush");
    check("sq_flush o_valid",  128'(o_valid),  128'(1'b1));
    check("sq_flush o_retire", 128'(o_retire), 128'(1'b1));
    check("sq_flush o_req",    128'(o_req),    128'(held));

    // Long stall: no acks, payload stable; release grants SQ retire.
    for (int k = 0; k < 5; k++) begin
      cycle(4'b0110, 1'b1, 1'b0, 4'b0000, "stall_hold");
      check("stall_hold o_req",   128'(o_req),   128'(held));
      check("stall_hold o_valid", 128'(o_valid), 128'(1'b1));
    end
    cycle(4'b0110, 1'b0, 1'b0, 4'b0010, "stall_release");

    // Reset mid-stall with LQ counter at 5: entry dropped, counter cleared.
    cycle(4'b0000, 1'b1, 1'b0, 4'b0000, "ctr_clear");
    for (int k = 0; k < 5; k++) cycle(4'b0101, 1'b1, 1'b0, 4'b0000, "pre_rst_wait");
    check("pre_rst o_valid", 128'(o_valid), 128'(1'b1));
    rst = 1'b1;
    cycle(4'b0101, 1'b1, 1'b0, 4'b0000, "mid_rst");
    check("mid_rst o_valid",  128'(o_valid),  128'(1'b0));
    check("mid_rst o_retire", 128'(o_retire), 128'(1'b0));
    check("mid_rst o_src",    128'(o_src),    128'(LSU_SRC_FILL));
    rst = 1'b0;
    for (int k = 0; k < 4; k++) cycle(4'b0101, 1'b0, 1'b0, 4'b0001, "post_rst");

    // SQ and RS both urgent: SQ first, RS on the next accept, then fill.
    for (int k = 0; k < STARVE_LIMIT; k++) cycle(4'b1011, 1'b1, 1'b0, 4'b0000, "urg_wait");
    cycle(4'b1011, 1'b0, 1'b0, 4'b0010, "urg_both");
    cycle(4'b1011, 1'b0, 1'b0, 4'b1000, "urg_next");
    cycle(4'b1011, 1'b0, 1'b0, 4'b0001, "urg_done");

    check("scoreboard empty", 128'(sb.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
